// File: rtl/axis_lane_repacker.sv
// AXI-Stream lane repacker: buffers LANE_W-bit lanes in a circular FIFO and emits
// fully packed OUT_LANES beats, flushed early at packet end or segment boundary.
module axis_lane_repacker #(
    parameter int LANE_W    = 4,
    parameter int IN_LANES  = 4,
    parameter int OUT_LANES = 4,
    parameter int DEPTH     = 32,
    parameter int SEG_W     = 12
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic [IN_LANES*LANE_W-1:0]  s_data,
    input  logic [IN_LANES-1:0]         s_keep,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [OUT_LANES*LANE_W-1:0] m_data,
    output logic [OUT_LANES-1:0]        m_keep,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    input  logic [SEG_W-1:0]            seg_len,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic                        keep_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LANE_W-1:0]           laneMem [DEPTH];
    logic                        endMem  [DEPTH];
    logic [PTR_W-1:0]            wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]            occ_q, occ_d;
    logic [SEG_W-1:0]            segCnt_q, segLen_q, effLen;
    logic [OUT_LANES*LANE_W-1:0] mData_q, candData;
    logic [OUT_LANES-1:0]        mKeep_q, candKeep;
    logic                        mValid_q, mLast_q, keepErr_q;
    logic                        keepOk, accept, doWrite;
    logic                        hitEnd, segEnd, beatReady, load;
    int                          nWr, kAvail, kRd, segRem;

    assign s_ready   = !arst && ((DEPTH - int'(occ_q)) >= IN_LANES);
    assign occupancy = occ_q;
    assign m_data    = mData_q;
    assign m_keep    = mKeep_q;
    assign m_valid   = mValid_q;
    assign m_last    = mLast_q;
    assign keep_err  = keepErr_q;

    // Input side: a keep mask is contiguous-low exactly when keep & (keep+1) is zero.
    always_comb begin
        keepOk  = ((s_keep & (s_keep + IN_LANES'(1))) == '0);
        nWr     = 0;
        for (int i = 0; i < IN_LANES; i++) begin
            nWr = nWr + (s_keep[i] ? 1 : 0);
        end
        accept  = s_valid && s_ready;
        doWrite = accept && keepOk;
    end

    // Candidate output beat; seg_len is only taken live at the start of a segment.
    always_comb begin
        effLen   = (segCnt_q == '0) ? seg_len : segLen_q;
        segRem   = (effLen != '0) ? int'(effLen) - int'(segCnt_q) : OUT_LANES;
        kAvail   = OUT_LANES;
        if (int'(occ_q) < kAvail) kAvail = int'(occ_q);
        if (segRem < kAvail)      kAvail = segRem;
        kRd      = kAvail;
        hitEnd   = 1'b0;
        candData = '0;
        candKeep = '0;
        for (int i = 0; i < OUT_LANES; i++) begin
            if (i < kAvail && !hitEnd) begin
                candData[i*LANE_W +: LANE_W] = laneMem[rdPtr_q + PTR_W'(i)];
                candKeep[i] = 1'b1;
                if (endMem[rdPtr_q + PTR_W'(i)]) begin
                    hitEnd = 1'b1;
                    kRd    = i + 1;
                end
            end
        end
        segEnd    = (effLen != '0) && (kRd == segRem);
        beatReady = (kRd > 0) && (hitEnd || kRd == OUT_LANES || segEnd);
        load      = beatReady && (!mValid_q || m_ready);
        occ_d     = CNT_W'(int'(occ_q) + (doWrite ? nWr : 0) - (load ? kRd : 0));
    end

    // Lane storage needs no reset: only lanes between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            for (int i = 0; i < IN_LANES; i++) begin
                if (i < nWr) begin
                    laneMem[wrPtr_q + PTR_W'(i)] <= s_data[i*LANE_W +: LANE_W];
                    endMem[wrPtr_q + PTR_W'(i)]  <= s_last && (i == nWr - 1);
                end
            end
            if (nWr == 0 && s_last && occ_q != '0) begin
                endMem[wrPtr_q - PTR_W'(1)] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            occ_q     <= '0;
            segCnt_q  <= '0;
            segLen_q  <= '0;
            mData_q   <= '0;
            mKeep_q   <= '0;
            mValid_q  <= 1'b0;
            mLast_q   <= 1'b0;
            keepErr_q <= 1'b0;
        end else begin
            keepErr_q <= accept && !keepOk;
            occ_q     <= occ_d;
            if (doWrite) begin
                wrPtr_q <= wrPtr_q + PTR_W'(nWr);
            end
            if (load) begin
                rdPtr_q  <= rdPtr_q + PTR_W'(kRd);
                mData_q  <= candData;
                mKeep_q  <= candKeep;
                mLast_q  <= hitEnd || segEnd;
                mValid_q <= 1'b1;
                if (segCnt_q == '0) begin
                    segLen_q <= seg_len;
                end
                if (hitEnd || segEnd || effLen == '0) begin
                    segCnt_q <= '0;
                end else begin
                    segCnt_q <= SEG_W'(int'(segCnt_q) + kRd);
                end
            end else if (m_ready) begin
                mValid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_lane_repacker.sv
// Self-checking bench for axis_lane_repacker: directed scenarios plus randomized
// packets compared against a lane-queue reference model.
module tb_axis_lane_repacker;

    logic        clk = 1'b0;
    logic        arst;
    logic [15:0] s_data;
    logic [3:0]  s_keep;
    logic        s_valid, s_last, s_ready;
    logic [15:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid, m_last, m_ready;
    logic [11:0] seg_len;
    logic [5:0]  occupancy;
    logic        keep_err;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int keepErrPulses = 0;
    int gotBase = 0;

    logic [15:0] gotData[$];
    logic [3:0]  gotKeep[$];
    logic        gotLast[$];
    int          gotCyc[$];
    logic [15:0] expData[$];
    logic [3:0]  expKeep[$];
    logic        expLast[$];

    // Reference model state: buffered lanes with their end-of-packet flags.
    logic [3:0]  mLane[$];
    logic        mEnd[$];
    int          mSegCnt = 0;
    int          mSegLen = 0;

    axis_lane_repacker dut (
        .clk(clk), .arst(arst),
        .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .seg_len(seg_len), .occupancy(occupancy), .keep_err(keep_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Output monitor: records every completed handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!arst && m_valid && m_ready) begin
            gotData.push_back(m_data);
            gotKeep.push_back(m_keep);
            gotLast.push_back(m_last);
            gotCyc.push_back(cycle);
        end
        if (!arst && keep_err) keepErrPulses = keepErrPulses + 1;
    end

    task automatic expBeat(input logic [15:0] d, input logic [3:0] k, input logic l);
        expData.push_back(d);
        expKeep.push_back(k);
        expLast.push_back(l);
    endtask

    task automatic clearAll();
        expData.delete(); expKeep.delete(); expLast.delete();
        mLane.delete(); mEnd.delete();
        mSegCnt = 0;
        mSegLen = 0;
        gotBase = gotData.size();
    endtask

    // Emits every beat the packing rules allow from the buffered lanes.
    task automatic modelForm();
        int eff, rem, k, take;
        bit hit, segB;
        logic [15:0] d;
        logic [3:0]  kp;
        while (mLane.size() > 0) begin
            eff = (mSegCnt == 0) ? int'(seg_len) : mSegLen;
            rem = (eff != 0) ? eff - mSegCnt : 4;
            k = 4;
            if (mLane.size() < k) k = mLane.size();
            if (rem < k) k = rem;
            take = k;
            hit = 0;
            for (int i = 0; i < k; i++) if (!hit && mEnd[i]) begin hit = 1; take = i + 1; end
            segB = (eff != 0) && (take == rem);
            if (!hit && take != 4 && !segB) break;
            mSegLen = eff;
            d = '0;
            kp = '0;
            for (int i = 0; i < take; i++) begin
                d[i*4 +: 4] = mLane.pop_front();
                void'(mEnd.pop_front());
                kp[i] = 1'b1;
            end
            expBeat(d, kp, hit || segB);
            mSegCnt = (hit || segB || eff == 0) ? 0 : mSegCnt + take;
        end
    endtask

    task automatic modelPush(input logic [15:0] d, input logic [3:0] keep, input logic last);
        int n = 0;
        for (int i = 0; i < 4; i++) if (keep[i]) n++;
        for (int i = 0; i < n; i++) begin
            mLane.push_back(d[i*4 +: 4]);
            mEnd.push_back(last && (i == n - 1));
        end
        if (n == 0 && last && mLane.size() > 0) mEnd[mLane.size() - 1] = 1'b1;
        modelForm();
    endtask

    // Drives one beat and returns 1 ns after the accepting edge, s_valid low.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] k, input logic l);
        int w = 0;
        s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && w < 300) begin w++; @(negedge clk); end
        if (!s_ready) begin
            checks++; errors++;
            $display("[TB] FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, w);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic waitOut(input int n);
        int c = 0;
        while (gotData.size() < gotBase + n && c < 600) begin @(posedge clk); c++; end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1; s_valid = 0; s_keep = 0; s_data = 0; s_last = 0; m_ready = 1; seg_len = 0;
        #2;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b required 0", m_valid); end
        checks++; if ({m_last, m_keep, m_data} !== 21'd0) begin errors++; $display("[TB] FAIL reset_m_out: got %b/%b/%h required 0", m_last, m_keep, m_data); end
        checks++; if (occupancy !== 6'd0) begin errors++; $display("[TB] FAIL reset_occupancy: got %0d required 0", occupancy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_ready: got %b required 0", s_ready); end
        checks++; if (keep_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_keep_err: got %b required 0", keep_err); end
        repeat (2) @(posedge clk);
        #3 arst = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_s_ready: got %b required 1", s_ready); end
    endtask

    task automatic test_full_beats();
        clearAll();
        expBeat(16'h3210, 4'hF, 0); expBeat(16'h7654, 4'hF, 0); expBeat(16'hBA98, 4'hF, 1);
        applyStimulus(16'h3210, 4'hF, 0);
        applyStimulus(16'h7654, 4'hF, 0);
        applyStimulus(16'hBA98, 4'hF, 1);
        waitOut(3);
        checks++; if (gotData.size() - gotBase !== 3) begin errors++; $display("[TB] FAIL full_count: got %0d required 3", gotData.size() - gotBase); end
        for (int i = 0; i < 3 && gotBase + i < gotData.size(); i++) begin
            checks++;
            if ({gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                errors++;
                $display("[TB] FAIL full_beat%0d: got %h/%b/%b required %h/%b/%b", i, gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i], expData[i], expKeep[i], expLast[i]);
            end
        end
    endtask

    task automatic test_latency();
        clearAll();
        applyStimulus(16'hABCD, 4'hF, 1);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: m_valid got %b required 0", m_valid); end
        @(posedge clk); #1;
        checks++; if ({m_valid, m_data, m_last} !== {1'b1, 16'hABCD, 1'b1}) begin errors++; $display("[TB] FAIL latency_beat: got %b/%h/%b required 1/abcd/1", m_valid, m_data, m_last); end
        waitOut(1);
    endtask

    task automatic test_partial_repack();
        clearAll();
        expBeat(16'h4321, 4'hF, 0); expBeat(16'h0065, 4'h3, 1);
        applyStimulus(16'h0021, 4'b0011, 0);
        applyStimulus(16'h0543, 4'b0111, 0);
        applyStimulus(16'h0006, 4'b0001, 1);
        waitOut(2);
        checks++; if (gotData.size() - gotBase !== 2) begin errors++; $display("[TB] FAIL repack_count: got %0d required 2", gotData.size() - gotBase); end
        for (int i = 0; i < 2 && gotBase + i < gotData.size(); i++) begin
            checks++;
            if ({gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                errors++;
                $display("[TB] FAIL repack_beat%0d: got %h/%b/%b required %h/%b/%b", i, gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i], expData[i], expKeep[i], expLast[i]);
            end
        end
    endtask

    task automatic test_zero_keep_last();
        clearAll();
        applyStimulus(16'h0021, 4'b0011, 0);
        applyStimulus(16'h0000, 4'b0000, 1);
        waitOut(1);
        checks++; if (gotData.size() - gotBase !== 1) begin errors++; $display("[TB] FAIL zerokeep_count: got %0d required 1", gotData.size() - gotBase); end
        else begin
            checks++;
            if ({gotData[gotBase], gotKeep[gotBase], gotLast[gotBase]} !== {16'h0021, 4'b0011, 1'b1}) begin
                errors++; $display("[TB] FAIL zerokeep_beat: got %h/%b/%b required 0021/0011/1", gotData[gotBase], gotKeep[gotBase], gotLast[gotBase]);
            end
        end
    endtask

    task automatic test_segmentation();
        clearAll();
        seg_len = 12'd6;
        expBeat(16'h3210, 4'hF, 0); expBeat(16'h0054, 4'h3, 1); expBeat(16'h9876, 4'hF, 0); expBeat(16'h00BA, 4'h3, 1);
        applyStimulus(16'h3210, 4'hF, 0);
        applyStimulus(16'h7654, 4'hF, 0);
        applyStimulus(16'hBA98, 4'hF, 1);
        waitOut(4);
        seg_len = 12'd0;
        checks++; if (gotData.size() - gotBase !== 4) begin errors++; $display("[TB] FAIL seg_count: got %0d required 4", gotData.size() - gotBase); end
        for (int i = 0; i < 4 && gotBase + i < gotData.size(); i++) begin
            checks++;
            if ({gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                errors++;
                $display("[TB] FAIL seg_beat%0d: got %h/%b/%b required %h/%b/%b", i, gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i], expData[i], expKeep[i], expLast[i]);
            end
        end
    endtask

    task automatic test_keep_err();
        int pulseBase;
        clearAll();
        pulseBase = keepErrPulses;
        applyStimulus(16'h0021, 4'b0011, 0);
        applyStimulus(16'h0505, 4'b0101, 0);
        checks++; if (keep_err !== 1'b1) begin errors++; $display("[TB] FAIL keep_err_pulse: got %b required 1", keep_err); end
        checks++; if (occupancy !== 6'd2) begin errors++; $display("[TB] FAIL keep_err_occ: got %0d required 2", occupancy); end
        @(posedge clk); #1;
        checks++; if (keep_err !== 1'b0) begin errors++; $display("[TB] FAIL keep_err_clear: got %b required 0", keep_err); end
        repeat (3) @(posedge clk); #1;
        checks++; if (gotData.size() !== gotBase || m_valid !== 1'b0) begin errors++; $display("[TB] FAIL keep_err_no_out: beats %0d m_valid %b required 0/0", gotData.size() - gotBase, m_valid); end
        checks++; if (keepErrPulses - pulseBase !== 1) begin errors++; $display("[TB] FAIL keep_err_count: got %0d required 1", keepErrPulses - pulseBase); end
        applyStimulus(16'h0043, 4'b0011, 1);
        waitOut(1);
        checks++; if (gotData.size() - gotBase !== 1) begin errors++; $display("[TB] FAIL keep_err_count_out: got %0d required 1", gotData.size() - gotBase); end
        else begin
            checks++;
            if ({gotData[gotBase], gotKeep[gotBase], gotLast[gotBase]} !== {16'h4321, 4'hF, 1'b1}) begin
                errors++; $display("[TB] FAIL keep_err_beat: got %h/%b/%b required 4321/1111/1", gotData[gotBase], gotKeep[gotBase], gotLast[gotBase]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clearAll();
        for (int i = 0; i < 4; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            applyStimulus(d, 4'hF, i == 3);
            modelPush(d, 4'hF, i == 3);
        end
        waitOut(4);
        checks++; if (gotData.size() - gotBase !== 4) begin errors++; $display("[TB] FAIL b2b_count: got %0d required 4", gotData.size() - gotBase); end
        else begin
            checks++; if (gotCyc[gotBase+3] - gotCyc[gotBase] !== 3) begin errors++; $display("[TB] FAIL b2b_span: got %0d cycles required 3", gotCyc[gotBase+3] - gotCyc[gotBase]); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                    errors++;
                    $display("[TB] FAIL b2b_beat%0d: got %h/%b/%b required %h/%b/%b", i, gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i], expData[i], expKeep[i], expLast[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] firstD;
        bit haveFirst = 0;
        bit sawFull = 0;
        bit acceptedNow;
        int n;
        clearAll();
        m_ready = 1'b0;
        s_valid = 1'b1; s_keep = 4'hF; s_last = 1'b0; s_data = 16'($urandom);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (s_ready !== (occupancy <= 6'd28)) begin errors++; $display("[TB] FAIL bp_s_ready: got %b at occupancy %0d", s_ready, occupancy); end
            if (!s_ready) sawFull = 1;
            if (m_valid) begin
                if (!haveFirst) begin firstD = m_data; haveFirst = 1; end
                else begin
                    checks++;
                    if (m_data !== firstD) begin errors++; $display("[TB] FAIL bp_hold: got %h required %h", m_data, firstD); end
                end
            end
            acceptedNow = s_ready;
            @(posedge clk); #1;
            if (acceptedNow) begin modelPush(s_data, 4'hF, 0); s_data = 16'($urandom); end
        end
        s_valid = 1'b0;
        checks++; if (sawFull !== 1'b1) begin errors++; $display("[TB] FAIL bp_full: s_ready never fell, got %b required 1", sawFull); end
        m_ready = 1'b1;
        applyStimulus(s_data, 4'hF, 1);
        modelPush(s_data, 4'hF, 1);
        n = expData.size();
        waitOut(n);
        checks++; if (gotData.size() - gotBase !== n) begin errors++; $display("[TB] FAIL bp_count: got %0d required %0d", gotData.size() - gotBase, n); end
        for (int i = 0; i < n && gotBase + i < gotData.size(); i++) begin
            checks++;
            if ({gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                errors++;
                $display("[TB] FAIL bp_beat%0d: got %h/%b/%b required %h/%b/%b", i, gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i], expData[i], expKeep[i], expLast[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        clearAll();
        m_ready = 1'b0;
        applyStimulus(16'h1111, 4'hF, 0);
        applyStimulus(16'h2222, 4'hF, 0);
        applyStimulus(16'h0003, 4'b0001, 0);
        checks++; if (occupancy !== 6'd5) begin errors++; $display("[TB] FAIL arst_pre_occ: got %0d required 5", occupancy); end
        #2 arst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_m_valid: got %b required 0", m_valid); end
        checks++; if (occupancy !== 6'd0) begin errors++; $display("[TB] FAIL arst_occ: got %0d required 0", occupancy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL arst_s_ready: got %b required 0", s_ready); end
        @(negedge clk);
        arst = 1'b0;
        m_ready = 1'b1;
        clearAll();
        @(posedge clk); #1;
        expBeat(16'h1357, 4'hF, 0); expBeat(16'h0042, 4'h3, 1);
        applyStimulus(16'h1357, 4'hF, 0);
        applyStimulus(16'hEE42, 4'b0011, 1);
        waitOut(2);
        checks++; if (gotData.size() - gotBase !== 2) begin errors++; $display("[TB] FAIL arst_count: got %0d required 2", gotData.size() - gotBase); end
        for (int i = 0; i < 2 && gotBase + i < gotData.size(); i++) begin
            checks++;
            if ({gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                errors++;
                $display("[TB] FAIL arst_beat%0d: got %h/%b/%b required %h/%b/%b", i, gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i], expData[i], expKeep[i], expLast[i]);
            end
        end
    endtask

    task automatic test_random();
        int segChoices[6] = '{0, 3, 5, 6, 7, 2};
        int n;
        clearAll();
        for (int p = 0; p < 6; p++) begin
            int nb;
            bit done;
            seg_len = 12'(segChoices[p]);
            nb = $urandom_range(2, 7);
            done = 0;
            fork
                begin
                    for (int b = 0; b < nb; b++) begin
                        logic [15:0] d;
                        logic [3:0] k;
                        d = 16'($urandom);
                        k = 4'((1 << $urandom_range(1, 4)) - 1);
                        applyStimulus(d, k, b == nb - 1);
                        modelPush(d, k, b == nb - 1);
                    end
                    done = 1;
                end
                begin
                    while (!done) begin
                        @(posedge clk); #1;
                        m_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            m_ready = 1'b1;
            waitOut(expData.size());
        end
        seg_len = 12'd0;
        n = expData.size();
        checks++; if (gotData.size() - gotBase !== n) begin errors++; $display("[TB] FAIL rand_count: got %0d required %0d", gotData.size() - gotBase, n); end
        for (int i = 0; i < n && gotBase + i < gotData.size(); i++) begin
            checks++;
            if ({gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i]} !== {expData[i], expKeep[i], expLast[i]}) begin
                errors++;
                $display("[TB] FAIL rand_beat%0d: got %h/%b/%b required %h/%b/%b", i, gotData[gotBase+i], gotKeep[gotBase+i], gotLast[gotBase+i], expData[i], expKeep[i], expLast[i]);
            end
        end
    endtask

    // Scenario sequence; each task leaves the pipeline drained and m_ready high.
    initial begin
        test_reset();
        test_full_beats();
        test_latency();
        test_partial_repack();
        test_zero_keep_last();
        test_segmentation();
        test_keep_err();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
